// File: rtl/symbol_serializer.sv
// Byte-to-symbol serializer for the modulator: MSB-first, 1 or 2 bits per symbol,
// each symbol held baud_div+1 clocks, with a zero-gap handoff to a follow-on word.
module symbol_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  qpsk,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [1:0]            en,
    output logic                  symbol_strobe,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int LW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DIV_WIDTH-1:0]  period_q, period_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]         left_q, left_d;
    logic                  mode_q, mode_d;
    logic [1:0]            en_d;
    logic                  strobe_d, busy_d, done_d;
    logic                  last_sym, accept;

    // Terminal cycle of the final symbol doubles as an accept slot so words chain without a gap.
    assign last_sym   = (state_q == SHIFT) && (cnt_q == '0) && (left_q == LW'(1));
    assign data_ready = !reset && ((state_q == IDLE) || last_sym);
    assign accept     = data_valid && data_ready;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        mode_d   = mode_q;
        en_d     = en;
        busy_d   = busy;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        if (accept) begin
            state_d  = SHIFT;
            shreg_d  = qpsk ? (data_in << 2) : (data_in << 1);
            en_d     = qpsk ? data_in[DATA_WIDTH-1 -: 2] : {1'b0, data_in[DATA_WIDTH-1]};
            period_d = baud_div;
            cnt_d    = baud_div;
            mode_d   = qpsk;
            left_d   = qpsk ? LW'(DATA_WIDTH / 2) : LW'(DATA_WIDTH);
            strobe_d = 1'b1;
            busy_d   = 1'b1;
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (left_q > LW'(1)) begin
                shreg_d  = mode_q ? (shreg_q << 2) : (shreg_q << 1);
                en_d     = mode_q ? shreg_q[DATA_WIDTH-1 -: 2] : {1'b0, shreg_q[DATA_WIDTH-1]};
                cnt_d    = period_q;
                left_d   = left_q - 1'b1;
                strobe_d = 1'b1;
            end else begin
                state_d = IDLE;
                en_d    = 2'b00;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            period_q      <= '0;
            cnt_q         <= '0;
            left_q        <= '0;
            mode_q        <= 1'b0;
            en            <= 2'b00;
            symbol_strobe <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            period_q      <= period_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            mode_q        <= mode_d;
            en            <= en_d;
            symbol_strobe <= strobe_d;
            busy          <= busy_d;
            frame_done    <= done_d;
        end
    end

endmodule

// File: tb/tb_symbol_serializer.sv
// Scoreboard bench for symbol_serializer: expected per-cycle symbols are queued at
// accept time and popped against the DUT on every falling edge.
module tb_symbol_serializer;

    localparam int DW = 8;
    localparam int DV = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [DV-1:0] baud_div;
    logic          qpsk;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic [1:0]    en;
    logic          symbol_strobe;
    logic          busy;
    logic          frame_done;

    typedef struct packed {
        logic [1:0] en;
        logic       strb;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    symbol_serializer #(.DATA_WIDTH(DW), .DIV_WIDTH(DV)) dut (
        .clk           (clk),
        .reset         (reset),
        .baud_div      (baud_div),
        .qpsk          (qpsk),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .en            (en),
        .symbol_strobe (symbol_strobe),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    function automatic void push_word(input logic [DW-1:0] d, input logic q, input int bd);
        logic [DW-1:0] t;
        logic [1:0]    sym;
        exp_t          e;
        int            n;
        t = d;
        n = q ? DW / 2 : DW;
        for (int s = 0; s < n; s++) begin
            if (q) begin
                sym = t[DW-1 -: 2];
                t   = t << 2;
            end else begin
                sym = {1'b0, t[DW-1]};
                t   = t << 1;
            end
            for (int c = 0; c <= bd; c++) begin
                e.en   = sym;
                e.strb = (c == 0);
                e.rdy  = (s == n - 1) && (c == bd);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Sends one word, checks every symbol cycle and the idle/frame_done tail.
    task automatic drive_word(input logic [DW-1:0] d, input logic q, input int bd, input int chg_at);
        exp_t e;
        int   cyc;
        @(negedge clk);
        data_in = d; qpsk = q; baud_div = DV'(bd); data_valid = 1'b1;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready word=%h got=%b want=1", d, data_ready);
        end
        push_word(d, q, bd);
        @(negedge clk);
        data_valid = 1'b0;
        cyc = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({en, symbol_strobe, busy, data_ready, frame_done} !== {e.en, e.strb, 1'b1, e.rdy, 1'b0}) begin
                errors++;
                $display("FAIL symbol word=%h cyc=%0d got en=%b stb=%b busy=%b rdy=%b fd=%b want en=%b stb=%b busy=1 rdy=%b fd=0",
                         d, cyc, en, symbol_strobe, busy, data_ready, frame_done, e.en, e.strb, e.rdy);
            end
            if (cyc == chg_at) begin
                baud_div = DV'(7);
                qpsk     = ~q;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({en, symbol_strobe, busy, frame_done, data_ready} !== 5'b00011) begin
            errors++;
            $display("FAIL word_end word=%h got en=%b stb=%b busy=%b fd=%b rdy=%b want 00 0 0 1 1",
                     d, en, symbol_strobe, busy, frame_done, data_ready);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_pulse word=%h got=%b want=0", d, frame_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; data_valid = 1'b0; baud_div = '0; qpsk = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({en, symbol_strobe, busy, frame_done, data_ready} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_state got en=%b stb=%b busy=%b fd=%b rdy=%b want all 0",
                     en, symbol_strobe, busy, frame_done, data_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b want=1", data_ready);
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({en, symbol_strobe, busy, frame_done, data_ready} !== 5'b00001) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got en=%b stb=%b busy=%b fd=%b rdy=%b want 00 0 0 0 1",
                         i, en, symbol_strobe, busy, frame_done, data_ready);
            end
        end
    endtask

    task automatic test_bpsk();
        drive_word(8'hA5, 1'b0, 3, 0);
    endtask

    task automatic test_qpsk_min();
        drive_word(8'h1B, 1'b1, 0, 0);
    endtask

    task automatic test_max_period();
        drive_word(8'hC3, 1'b1, (1 << DV) - 1, 0);
    endtask

    task automatic test_config_ignored();
        drive_word(8'h96, 1'b0, 1, 5);
        drive_word(8'h2D, 1'b1, 7, 0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc, rdy_cnt, fd_cnt;
        rdy_cnt = 0; fd_cnt = 0;
        @(negedge clk);
        data_in = 8'hFF; qpsk = 1'b0; baud_div = DV'(1); data_valid = 1'b1;
        push_word(8'hFF, 1'b0, 1);
        push_word(8'h00, 1'b0, 1);
        @(negedge clk);
        data_in = 8'h00;
        cyc = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (cyc <= 16 && data_ready) rdy_cnt++;
            if (frame_done) fd_cnt++;
            checks++;
            if ({en, symbol_strobe, busy, data_ready} !== {e.en, e.strb, 1'b1, e.rdy}) begin
                errors++;
                $display("FAIL b2b_symbol cyc=%0d got en=%b stb=%b busy=%b rdy=%b want en=%b stb=%b busy=1 rdy=%b",
                         cyc, en, symbol_strobe, busy, data_ready, e.en, e.strb, e.rdy);
            end
            @(negedge clk);
            cyc++;
            if (cyc == 17) data_valid = 1'b0;
        end
        checks++;
        if (rdy_cnt !== 1) begin
            errors++;
            $display("FAIL b2b_ready_count got=%0d want=1", rdy_cnt);
        end
        checks++;
        if (fd_cnt !== 0) begin
            errors++;
            $display("FAIL b2b_early_frame_done got=%0d want=0", fd_cnt);
        end
        checks++;
        if ({en, busy, frame_done} !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_end got en=%b busy=%b fd=%b want en=00 busy=0 fd=1", en, busy, frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fd_pulse got=%b want=0", frame_done);
        end
    endtask

    task automatic test_reset_mid_word();
        @(negedge clk);
        data_in = 8'hFF; qpsk = 1'b0; baud_div = DV'(3); data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if ({en, busy} !== 3'b011) begin
            errors++;
            $display("FAIL mid_word_active got en=%b busy=%b want en=01 busy=1", en, busy);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({en, symbol_strobe, busy, frame_done, data_ready} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_abort cyc=%0d got en=%b stb=%b busy=%b fd=%b rdy=%b want all 0",
                         i, en, symbol_strobe, busy, frame_done, data_ready);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_abort got=%b want=1", data_ready);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if ({en, symbol_strobe, busy, frame_done} !== 5'b00000) begin
                errors++;
                $display("FAIL residual cyc=%0d got en=%b stb=%b busy=%b fd=%b want all 0",
                         i, en, symbol_strobe, busy, frame_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_hold();
        test_bpsk();
        test_qpsk_min();
        test_back_to_back();
        test_config_ignored();
        test_max_period();
        test_reset_mid_word();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/symbol_serializer.md
# symbol_serializer

Upstream stage of the modulator. Accepts data bytes over a valid/ready handshake and serializes them MSB-first into modulation symbols on `en[1:0]`. Each symbol is held for a programmable number of clock cycles (the baud period). Supports 1 bit/symbol (ASK/FSK/BPSK/OOK) and 2 bits/symbol (QPSK). `en` connects directly to the modulator's `en` input.

## Interface

**Parameters**
- `DATA_WIDTH`, default 8: bits per input word; must be even.
- `DIV_WIDTH`, default 16: width of the baud divider.

**Ports**
- `clk`, input, 1: system clock; all logic on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `baud_div`, input, `DIV_WIDTH`: symbol period minus 1, in clock cycles.
- `qpsk`, input, 1: 0 = 1 bit/symbol; 1 = 2 bits/symbol.
- `data_in`, input, `DATA_WIDTH`: word to transmit.
- `data_valid`, input, 1: `data_in` is valid.
- `data_ready`, output, 1: block can accept a word this cycle.
- `en`, output, 2: current symbol to the modulator.
- `symbol_strobe`, output, 1: one-cycle pulse on the first cycle of each new symbol.
- `busy`, output, 1: a word is being transmitted.
- `frame_done`, output, 1: one-cycle pulse when the final symbol ends with no follow-on word.

## Operation

**Reset**
- `en`=00, `symbol_strobe`=0, `busy`=0, `frame_done`=0, state=IDLE.
- `data_ready`=0 in every cycle where `reset` is high.

**States**
- IDLE: `data_ready`=1, `en`=00, `busy`=0.
- SHIFT: `busy`=1.

**Accept**
- A word is accepted when `data_valid` & `data_ready` are both high at a rising edge.
- On accept, the block captures `data_in` into the shift register, `baud_div` into the period register, and `qpsk` into the mode register.
- It loads the symbol counter with `DATA_WIDTH` (1-bit mode) or `DATA_WIDTH/2` (QPSK mode), and enters SHIFT.
- `baud_div` and `qpsk` are ignored at all other times; mid-word changes have no effect.

**Symbol mapping**
- 1-bit mode: `en` = {0, bit}, MSB first.
- QPSK mode: `en` = {bit[n], bit[n-1]}, MSB pair first.

**Symbol period**
- The down-counter loads the captured period at the start of each symbol.
- When the counter reaches 0:
  - If symbols remain: shift the next symbol onto `en` and pulse `symbol_strobe`.
  - If this was the last symbol, see the two cases below.

**Back-to-back words**
- `data_ready` is also 1 during the terminal cycle of the last symbol (counter=0, symbols left=1).
- If a word is accepted in that cycle, its first symbol appears on the next cycle. There is no gap, no `frame_done`, and `busy` stays 1.

**End of word, no follow-on**
- Return to IDLE: `en`=00, `busy`=0, `frame_done` pulses for 1 cycle.

**Other rules**
- `baud_div`=0 gives 1 clock per symbol.
- The maximum `baud_div` gives 2^`DIV_WIDTH` clocks per symbol; the counter must not wrap.
- Reset asserted mid-word aborts immediately: no `frame_done`, the remaining bits are discarded, and all outputs take their reset values on the next edge.

## Timing

- Accept at edge T: on cycle T+1, `en` = first symbol, `symbol_strobe`=1, `busy`=1.
- Each symbol lasts exactly `baud_div`+1 cycles. `symbol_strobe` is high on its first cycle only.
- A word lasts N·(`baud_div`+1) cycles, where N = `DATA_WIDTH` or `DATA_WIDTH/2`.
- Without a follow-on word, IDLE (`en`=00, `frame_done`=1) is on cycle T+1+N·(`baud_div`+1). `frame_done` is low one cycle later.
- All outputs are registered, except `data_ready`, which is combinational from state, counters and `reset`.
- `data_ready` does not depend on `data_valid`.

## Test plan

- **BPSK timing:** reset, then `qpsk`=0, `baud_div`=3, accept 0xA5 at T → `en[0]` = 1,0,1,0,0,1,0,1, each held 4 cycles from T+1; `en[1]`=0 throughout; 8 strobes; `frame_done` at T+33; `busy` falls at T+33.
- **QPSK at minimum period:** `qpsk`=1, `baud_div`=0, accept 0x1B → `en` = 00, 01, 10, 11 on cycles T+1..T+4; `frame_done` at T+5.
- **Back-to-back words:** `baud_div`=1, `data_valid` held high with 0xFF then 0x00 → `en[0]`=1 for 16 cycles, then 0 for 16 cycles, no gap; exactly one `frame_done`; `data_ready` high on exactly one cycle during the first word.
- **Config ignored mid-word:** change `baud_div` to 7 and `qpsk` to 1 mid-word → the current word completes with the original period and mode; the next word uses the new values.
- **Reset mid-word:** assert `reset` during the 3rd symbol → next cycle `en`=00, `busy`=0, `frame_done`=0, `data_ready`=0 while reset is high and 1 afterward; no residual symbols appear.
- **Idle hold:** `data_valid`=0 for 100 cycles after reset → `en`=00, no strobes, `data_ready`=1.
